// File: rtl/urisc_run_ctrl.sv
// Run controller: loads a program image, runs the core under a cycle budget, dumps memory back.
// Build option URISC_RUN_CTRL_DUMP_EN enables the memory dump phase after the run.
module urisc_run_ctrl #(
    parameter int unsigned CYC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             load_valid,
    input  logic [7:0]       load_data,
    output logic             load_ready,
    output logic             cpu_reset,
    input  logic             cpu_halt,
    input  logic [7:0]       cpu_addr,
    input  logic [7:0]       cpu_wdata,
    input  logic             cpu_we,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             mem_we,
    input  logic [7:0]       mem_rdata,
    output logic             dump_valid,
    output logic [7:0]       dump_data,
    input  logic             dump_ready,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CYC_W-1:0] cycles
);

`ifdef URISC_RUN_CTRL_DUMP_EN
    typedef enum logic [2:0] {StIdle, StHdr, StLoad, StRun, StDump, StDone} state_t;
`else
    typedef enum logic [2:0] {StIdle, StHdr, StLoad, StRun, StDone} state_t;
`endif

    state_t           state_q, state_d;
    logic [8:0]       len_q, len_d;
    logic [8:0]       addr_q, addr_d;
    logic [8:0]       addr_inc;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             timeout_q, timeout_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;

    assign addr_inc = addr_q + 9'd1;
    assign timeout  = timeout_q;
    assign cycles   = cycles_q;

`ifndef URISC_RUN_CTRL_DUMP_EN
    logic unused_dump;
    assign unused_dump = ^{dump_ready, mem_rdata};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            len_q     <= '0;
            addr_q    <= '0;
            cyc_q     <= '0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            cyc_q     <= cyc_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        cyc_d      = cyc_q;
        timeout_d  = timeout_q;
        cycles_d   = cycles_q;
        load_ready = 1'b0;
        cpu_reset  = 1'b1;
        mem_addr   = addr_q[7:0];
        mem_wdata  = load_data;
        mem_we     = 1'b0;
        dump_valid = 1'b0;
        dump_data  = 8'h00;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = StHdr;
                    timeout_d = 1'b0;
                end
            end
            StHdr: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    // A zero header encodes a full 256-byte image.
                    len_d   = (load_data == 8'h00) ? 9'd256 : {1'b0, load_data};
                    addr_d  = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_we = 1'b1;
                    addr_d = addr_inc;
                    if (addr_inc == len_q) begin
                        addr_d  = '0;
                        cyc_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                cpu_reset = 1'b0;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
                cyc_d     = cyc_q + 1'b1;
                // Halt takes priority over budget exhaustion in the same cycle.
                if (cpu_halt || (cyc_q == {CYC_W{1'b1}})) begin
                    timeout_d = !cpu_halt;
                    cycles_d  = cyc_q;
`ifdef URISC_RUN_CTRL_DUMP_EN
                    state_d   = StDump;
`else
                    state_d   = StDone;
`endif
                end
            end
`ifdef URISC_RUN_CTRL_DUMP_EN
            StDump: begin
                dump_valid = 1'b1;
                dump_data  = mem_rdata;
                if (dump_ready) begin
                    addr_d = addr_inc;
                    if (addr_inc == len_q) begin
                        state_d = StDone;
                    end
                end
            end
`endif
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_urisc_run_ctrl.sv
// Directed bench for urisc_run_ctrl with a behavioural async-read memory; follows the
// URISC_RUN_CTRL_DUMP_EN build option of the design.
module tb_urisc_run_ctrl;

    localparam int unsigned CYC_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             load_valid = 1'b0;
    logic [7:0]       load_data = 8'h00;
    logic             load_ready;
    logic             cpu_reset;
    logic             cpu_halt = 1'b0;
    logic [7:0]       cpu_addr = 8'h00;
    logic [7:0]       cpu_wdata = 8'h00;
    logic             cpu_we = 1'b0;
    logic [7:0]       mem_addr;
    logic [7:0]       mem_wdata;
    logic             mem_we;
    logic [7:0]       mem_rdata;
    logic             dump_valid;
    logic [7:0]       dump_data;
    logic             dump_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CYC_W-1:0] cycles;

    logic [7:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    urisc_run_ctrl #(.CYC_W(CYC_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
        .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then present the header byte; leaves the controller in LOAD.
    task automatic begin_seq(input logic [7:0] hdr);
        start = 1'b1;
        tick();
        start = 1'b0;
        load_valid = 1'b1;
        load_data = hdr;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL rst_load_ready got %b exp 0", load_ready); end
        n_cmp++; if (dump_valid !== 1'b0) begin n_err++; $display("FAIL rst_dump_valid got %b exp 0", dump_valid); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", done); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout got %b exp 0", timeout); end
        n_cmp++; if (cycles !== 4'd0) begin n_err++; $display("FAIL rst_cycles got %0d exp 0", cycles); end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        begin_seq(8'd5);
        n_cmp++; if (load_ready !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL mid_load_ready got %b/%b exp 1/1", load_ready, busy);
        end
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_data = 8'hA0 + 8'(i);
            tick();
        end
        load_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL mid_rst_cpu_reset got %b exp 1", cpu_reset); end
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_load_ready got %b exp 0", load_ready); end
    endtask

    task automatic test_load_run_halt();
        logic [7:0] img [4];
        img[0] = 8'h05; img[1] = 8'h06; img[2] = 8'h07; img[3] = 8'hFF;
        begin_seq(8'd4);
        // Valid on odd cycles only: accepts at i = 1, 3, 5, 7.
        for (int i = 0; i < 8; i++) begin
            load_valid = i[0];
            load_data = i[0] ? img[i/2] : 8'h99;
            #1;
            n_cmp++; if (mem_we !== i[0]) begin
                n_err++; $display("FAIL load_we[%0d] got %b exp %b", i, mem_we, i[0]);
            end
            if (i[0]) begin
                n_cmp++; if (mem_addr !== 8'(i/2) || mem_wdata !== img[i/2]) begin
                    n_err++; $display("FAIL load_wr[%0d] got %h:%h exp %h:%h",
                                      i, mem_addr, mem_wdata, 8'(i/2), img[i/2]);
                end
            end
            tick();
        end
        load_valid = 1'b0;
        n_cmp++; if (cpu_reset !== 1'b0 || load_ready !== 1'b0) begin
            n_err++; $display("FAIL run_entry got %b/%b exp 0/0", cpu_reset, load_ready);
        end
        for (int k = 0; k <= 10; k++) begin
            cpu_halt = (k == 10);
            start = (k == 5);
            cpu_we = (k == 3);
            cpu_addr = 8'h40;
            cpu_wdata = 8'hAB;
            #1;
            if (k == 3) begin
                n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 8'hAB) begin
                    n_err++; $display("FAIL run_pass got %b %h %h exp 1 40 ab", mem_we, mem_addr, mem_wdata);
                end
            end
            if (k == 6) begin
                n_cmp++; if (cpu_reset !== 1'b0) begin
                    n_err++; $display("FAIL run_start_ignored got %b exp 0", cpu_reset);
                end
            end
            tick();
        end
        cpu_halt = 1'b0; start = 1'b0; cpu_we = 1'b0;
        n_cmp++; if (cycles !== 4'd10) begin n_err++; $display("FAIL halt_cycles got %0d exp 10", cycles); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL halt_timeout got %b exp 0", timeout); end
        n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL halt_cpu_reset got %b exp 1", cpu_reset); end
`ifdef URISC_RUN_CTRL_DUMP_EN
        for (int j = 0; j < 4; j++) begin
            dump_ready = 1'b0;
            start = (j == 1);
            #1;
            n_cmp++; if (dump_valid !== 1'b1 || dump_data !== img[j] || mem_we !== 1'b0) begin
                n_err++; $display("FAIL dump_stall[%0d] got %b %h exp 1 %h", j, dump_valid, dump_data, img[j]);
            end
            tick();
            start = 1'b0;
            dump_ready = 1'b1;
            #1;
            n_cmp++; if (dump_data !== img[j] || mem_addr !== 8'(j)) begin
                n_err++; $display("FAIL dump_hold[%0d] got %h@%h exp %h@%h", j, dump_data, mem_addr, img[j], 8'(j));
            end
            tick();
        end
        dump_ready = 1'b0;
`else
        n_cmp++; if (dump_valid !== 1'b0) begin n_err++; $display("FAIL nodump_valid got %b exp 0", dump_valid); end
`endif
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_pulse got %b exp 1", done); end
        tick();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL done_once got %b/%b exp 0/0", done, busy);
        end
        n_cmp++; if (mem[8'h40] !== 8'hAB) begin
            n_err++; $display("FAIL run_mem_write got %h exp ab", mem[8'h40]);
        end
    endtask

    // One-byte image; halt asserted at RUN index halt_at (use a large value for never).
    task automatic run_one(input logic [7:0] b, input int halt_at, input logic exp_to,
                           input string name);
        int runcnt;
        begin_seq(8'd1);
        load_valid = 1'b1;
        load_data = b;
        tick();
        load_valid = 1'b0;
        runcnt = 0;
        while (cpu_reset === 1'b0 && runcnt < 40) begin
            cpu_halt = (runcnt == halt_at);
            tick();
            runcnt++;
        end
        cpu_halt = 1'b0;
        n_cmp++; if (runcnt != 16) begin n_err++; $display("FAIL %s_runlen got %0d exp 16", name, runcnt); end
        n_cmp++; if (timeout !== exp_to) begin n_err++; $display("FAIL %s_timeout got %b exp %b", name, timeout, exp_to); end
        n_cmp++; if (cycles !== 4'd15) begin n_err++; $display("FAIL %s_cycles got %0d exp 15", name, cycles); end
`ifdef URISC_RUN_CTRL_DUMP_EN
        dump_ready = 1'b1;
        #1;
        n_cmp++; if (dump_valid !== 1'b1 || dump_data !== b) begin
            n_err++; $display("FAIL %s_dump got %b %h exp 1 %h", name, dump_valid, dump_data, b);
        end
        tick();
        dump_ready = 1'b0;
`endif
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL %s_done got %b exp 1", name, done); end
        tick();
    endtask

    task automatic test_timeout();
        run_one(8'h5A, 1000, 1'b1, "timeout");
    endtask

    task automatic test_halt_saturate();
        run_one(8'hC3, 15, 1'b0, "halt_sat");
    endtask

    task automatic test_full_image();
        int bad;
        int n;
        bad = 0;
        begin_seq(8'h00);
        load_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            load_data = 8'(i) ^ 8'h3C;
            #1;
            if (mem_we !== 1'b1 || mem_addr !== 8'(i) || cpu_reset !== 1'b1) bad++;
            tick();
        end
        load_valid = 1'b0;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL full_load got %0d bad exp 0", bad); end
        n_cmp++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL full_run got %b exp 0", cpu_reset); end
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        n_cmp++; if (cycles !== 4'd0) begin n_err++; $display("FAIL full_cycles got %0d exp 0", cycles); end
`ifdef URISC_RUN_CTRL_DUMP_EN
        dump_ready = 1'b1;
        bad = 0;
        n = 0;
        while (dump_valid === 1'b1 && n < 300) begin
            if (dump_data !== (8'(n) ^ 8'h3C) || mem_addr !== 8'(n)) bad++;
            tick();
            n++;
        end
        dump_ready = 1'b0;
        n_cmp++; if (n != 256 || bad != 0) begin
            n_err++; $display("FAIL full_dump got %0d bytes %0d bad exp 256 0", n, bad);
        end
`else
        n = 0;
`endif
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done got %b exp 1", done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_load_run_halt();
        test_timeout();
        test_halt_saturate();
        test_full_image();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/urisc_run_ctrl.md
# urisc_run_ctrl

Run controller for the ultimate-RISC core and its single-port 8-bit memory. It holds the core in reset, streams a program image into memory, and releases the core. It then watches for halt or a cycle-budget timeout and streams the memory contents back out. It sits between the core and the memory: it owns the memory port except during the run phase, and it drives the core's reset.

## Interface
Parameters:
- CYC_W, 16, width of run-cycle counter; timeout when counter reaches 2^CYC_W-1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load/run/dump sequence from IDLE
- load_valid  in  1  program byte valid
- load_data  in  8  program byte
- load_ready  out  1  controller accepts load_data this cycle
- cpu_reset  out  1  drives core reset input
- cpu_halt  in  1  high while core is in its HALT state
- cpu_addr  in  8  core memory address
- cpu_wdata  in  8  core write data
- cpu_we  in  1  core write enable
- mem_addr  out  8  memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  8  memory read data (asynchronous read)
- dump_valid  out  1  dump byte valid
- dump_data  out  8  dump byte
- dump_ready  in  1  consumer accepts dump byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of sequence
- timeout  out  1  registered; set if last run ended on budget, cleared on start
- cycles  out  CYC_W  registered run-cycle count of last run

## Operation
States:
- IDLE: cpu_reset=1, mem_we=0. start -> HDR.
- HDR: load_ready=1. An accepted byte (load_valid&&load_ready) is N, the image length; 0 means 256. Go to LOAD; clear addr counter.
- LOAD: load_ready=1. Each accepted byte drives mem_we=1, mem_addr=addr counter and mem_wdata=load_data in the same cycle, then the addr counter increments. After byte N is written -> RUN.
- RUN: cpu_reset=0. mem_addr, mem_wdata and mem_we pass through from cpu_*. The cycle counter starts at 0 on entry and increments each RUN cycle.
  - cpu_halt=1 -> DUMP, timeout<=0.
  - Otherwise, counter == 2^CYC_W-1 -> DUMP, timeout<=1.
  - On exit, cycles<=counter. If halt and saturation occur in the same cycle, halt wins.
- DUMP: cpu_reset=1, mem_we=0, mem_addr=dump counter (starts 0). dump_valid=1 and dump_data=mem_rdata (combinational). On dump_ready the counter increments. After N bytes -> DONE.
- DONE: done=1 for one cycle -> IDLE.

Rules:
- start outside IDLE is ignored.
- load_valid is ignored outside HDR/LOAD.
- load_ready and dump_valid are 0 in all other states.
- Counters are 9-bit to represent N=256. mem_addr uses the low 8 bits.

## Timing
Reset values (next cycle after reset high):
- State is IDLE.
- cpu_reset=1.
- load_ready=0, dump_valid=0, mem_we=0.
- busy=0, done=0, timeout=0, cycles=0.
- Counters are 0.
- Reset mid-sequence aborts immediately to IDLE. Memory contents are left as is.

Cycle behaviour:
- start in cycle t puts the controller in HDR at t+1.
- load_ready is asserted combinationally from state, with no dependency on load_valid.
- The load write occurs in the acceptance cycle.
- The last LOAD accept at t gives RUN at t+1 with cpu_reset=0. The core sees reset low at the t+1 edge and enters its first fetch state at t+2. The cycle count includes the t+1 cycle.
- cpu_halt high in cycle t gives DUMP at t+1 with cpu_reset=1.
- The dump byte is valid in the same cycle as mem_addr. dump_data must be held stable while dump_valid && !dump_ready.
- A sequence with N=1 takes one HDR byte, one LOAD byte and one dump byte.

## Configuration
- URISC_RUN_CTRL_DUMP_EN
  - Defined: DUMP state present, as described above.
  - Undefined: RUN exits directly to DONE, the DUMP state is removed, dump_valid is tied 0 and dump_data is tied 0. The dump_ready input is ignored.

## Test plan
- Reset mid-LOAD after 3 of 5 bytes -> IDLE next cycle, busy=0, cpu_reset=1, load_ready=0. A following start reloads from address 0.
- Load N=4, bytes {8'h05,8'h06,8'h07,8'hFF}, with load_valid gapped every other cycle -> mem writes at addr 0..3 only on accept cycles. RUN is entered the cycle after the 4th accept.
- Core model raises cpu_halt 10 cycles into RUN -> cycles=10, timeout=0. Dump emits 4 bytes equal to memory. With dump_ready toggling, dump_data is held while stalled. done pulses once.
- CYC_W=4 with cpu_halt never asserted -> exit RUN at count 15, timeout=1, cycles=15, dump proceeds.
- HDR byte 8'h00 -> exactly 256 loads (addr 0..255) and 256 dump bytes.
- Halt and saturation in the same cycle -> timeout=0. start pulses during RUN/DUMP are ignored. Without URISC_RUN_CTRL_DUMP_EN, dump_valid stays 0 and done follows RUN by 1 cycle.
